// File: rtl/aes_v3_col_seq_pkg.sv
// Shared definitions for the AES column sequencer: FSM state encoding, GF(2^8)
// arithmetic helpers and the (Inv)MixColumns coefficient words.
package aes_v3_col_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Coefficients laid out as result bytes {b3, b2, b1, b0} for one input byte.
  localparam logic [31:0] MixCoefEnc = {8'd3, 8'd1, 8'd1, 8'd2};
  localparam logic [31:0] MixCoefDec = {8'd11, 8'd13, 8'd9, 8'd14};

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product a * n by shift-and-add over the bits of n.
  function automatic logic [7:0] xtime_n(input logic [7:0] a, input logic [7:0] n);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (n[i]) p = p ^ x;
      x = xtime2(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = xtime_n(sq, sq);
      acc = xtime_n(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box / inverse S-box, purely combinational.
// Ports:
//   inv  in  1  0 = forward S-box, 1 = inverse S-box
//   in   in  8  input byte
//   out  out 8  substituted byte
module aes_sbox
  import aes_v3_col_seq_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] in,
  output logic [7:0] out
);

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] post;

  // Forward: affine(inverse(x)); inverse: inverse(affine^-1(x)).
  always_comb begin
    pre  = inv ? inv_affine(in) : in;
    post = gf_inv(pre);
    out  = inv ? post : fwd_affine(post);
  end

endmodule

// File: rtl/aes_v3_col_seq.sv
// Multi-cycle AES column sequencer. Issues four byte-wise saes.v3 steps
// (bs = 0..3) through one shared byte datapath and XOR-accumulates the
// rotated results onto the rs2 seed.
// Ports:
//   g_clk      in   1   clock, rising edge
//   g_resetn   in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   high only while idle
//   req_dec    in   1   0 = encrypt, 1 = decrypt
//   req_mix    in   1   0 = S-box only, 1 = (Inv)MixColumns only
//   req_rs1    in   32  input column
//   req_rs2    in   32  accumulator seed
//   rsp_valid  out  1   result valid, held until rsp_ready
//   rsp_ready  in   1   consumer accept
//   rsp_rd     out  32  result, holds its last value outside DONE
module aes_v3_col_seq
  import aes_v3_col_seq_pkg::*;
#(
  parameter bit GATE_IDLE = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dec,
  input  logic        req_mix,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rd_q, rd_d;
  logic        dec_q, dec_d;
  logic        mix_q, mix_d;

  logic        busy;
  logic        sbox_inv;
  logic [7:0]  byte_sel;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic [31:0] coef;
  logic [31:0] r_word;
  logic [31:0] r_rot;

  assign busy     = (state_q == StBusy);
  assign sbox_inv = dec_q && busy;

  always_comb begin
    byte_sel = rs1_q[7:0];
    case (cnt_q)
      2'd0:    byte_sel = rs1_q[7:0];
      2'd1:    byte_sel = rs1_q[15:8];
      2'd2:    byte_sel = rs1_q[23:16];
      default: byte_sel = rs1_q[31:24];
    endcase
  end

  // Quiet the shared byte datapath outside BUSY when gating is enabled.
  assign sbox_in = (GATE_IDLE && !busy) ? 8'h00 : byte_sel;

  aes_sbox u_sbox (
    .inv (sbox_inv),
    .in  (sbox_in),
    .out (sbox_out)
  );

  always_comb begin
    coef   = dec_q ? MixCoefDec : MixCoefEnc;
    r_word = {24'h000000, sbox_out};
    if (mix_q) begin
      for (int k = 0; k < 4; k++) begin
        r_word[8*k +: 8] = xtime_n(sbox_in, coef[8*k +: 8]);
      end
    end
  end

  // rotl(r_word, 8*cnt)
  always_comb begin
    r_rot = r_word;
    case (cnt_q)
      2'd0:    r_rot = r_word;
      2'd1:    r_rot = {r_word[23:0], r_word[31:24]};
      2'd2:    r_rot = {r_word[15:0], r_word[31:16]};
      default: r_rot = {r_word[7:0], r_word[31:8]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    dec_d     = dec_q;
    mix_d     = mix_q;
    acc_d     = acc_q;
    rd_d      = rd_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = StBusy;
          rs1_d   = req_rs1;
          dec_d   = req_dec;
          mix_d   = req_mix;
          acc_d   = req_rs2;
          cnt_d   = 2'd0;
        end
      end
      StBusy: begin
        acc_d = acc_q ^ r_rot;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = StDone;
          // Separate result register keeps rsp_rd stable across later BUSY phases.
          rd_d    = acc_q ^ r_rot;
        end
      end
      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_rd = rd_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      rs1_q   <= 32'h0;
      dec_q   <= 1'b0;
      mix_q   <= 1'b0;
      acc_q   <= 32'h0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      dec_q   <= dec_d;
      mix_q   <= mix_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_aes_v3_col_seq.sv
// Self-checking bench for aes_v3_col_seq: a column-level AES model plus a
// cycle-level handshake model checked on every falling edge.
module tb_aes_v3_col_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_dec;
  logic        req_mix;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;

  aes_v3_col_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_mix   (req_mix),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd)
  );

  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  // Polynomial product, then reduction mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] t;
    t = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) t = t ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (t[i]) t = t ^ (16'h011b << (i - 8));
    return t[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] xi;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      xi = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = xi[i] ^ xi[(i+4)%8] ^ xi[(i+5)%8] ^ xi[(i+6)%8] ^ xi[(i+7)%8] ^ c[i];
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model_col(input logic d, input logic m,
                                            input logic [31:0] a, input logic [31:0] key);
    logic [7:0] b [4];
    logic [7:0] o [4];
    for (int i = 0; i < 4; i++) b[i] = a[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      if (!m) o[i] = d ? isbox_t[b[i]] : sbox_t[b[i]];
      else if (!d)
        o[i] = gmul(b[i], 8'd2) ^ gmul(b[(i+1)%4], 8'd3) ^ b[(i+2)%4] ^ b[(i+3)%4];
      else
        o[i] = gmul(b[i], 8'd14) ^ gmul(b[(i+1)%4], 8'd11) ^ gmul(b[(i+2)%4], 8'd13)
             ^ gmul(b[(i+3)%4], 8'd9);
    end
    return {o[3], o[2], o[1], o[0]} ^ key;
  endfunction

  // ---------------- cycle-level handshake model ----------------
  int          cyc = 0;
  bit          pend = 1'b0;
  int          acc_cyc;
  logic [31:0] exp_rd;
  int          n_acc = 0;
  int          n_done = 0;
  logic [31:0] last_rsp = 32'h0;
  int          k;

  always @(posedge g_clk) cyc++;

  always @(negedge g_clk) begin
    if (!g_resetn) begin
      pend = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rd", rsp_rd, 32'h0);
    end else begin
      if (!pend) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        k = cyc - acc_cyc;
        chk("op_req_ready", 32'(req_ready), 32'd0);
        chk("op_rsp_valid", 32'(rsp_valid), 32'(k >= 5));
        if (k >= 5) chk("op_rsp_rd", rsp_rd, exp_rd);
      end
      if (pend && (cyc - acc_cyc) >= 5 && rsp_ready) begin
        pend     = 1'b0;
        last_rsp = rsp_rd;
        n_done++;
      end else if (!pend && req_valid) begin
        pend    = 1'b1;
        acc_cyc = cyc;
        exp_rd  = model_col(req_dec, req_mix, req_rs1, req_rs2);
        n_acc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_acc(input int base);
    int n;
    n = 0;
    while (n_acc == base && n < 30) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n_acc == base) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (n_done == base && n < 40) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n_done == base) chk("response_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_req(input string name, input logic d, input logic m,
                         input logic [31:0] a, input logic [31:0] key,
                         input logic [31:0] lit);
    int base;
    @(posedge g_clk); #1;
    base      = n_acc;
    req_valid = 1'b1;
    req_dec   = d;
    req_mix   = m;
    req_rs1   = a;
    req_rs2   = key;
    rsp_ready = 1'b1;
    wait_acc(base);
    // Scramble inputs after accept: they must have no effect.
    req_valid = 1'b0;
    req_dec   = ~d;
    req_mix   = ~m;
    req_rs1   = ~a;
    req_rs2   = 32'hdeadbeef;
    base      = n_done;
    wait_done(base);
    chk(name, last_rsp, lit);
  endtask

  initial begin
    int base;
    g_resetn  = 1'b0;
    req_valid = 1'b0;
    req_dec   = 1'b0;
    req_mix   = 1'b0;
    req_rs1   = 32'h0;
    req_rs2   = 32'h0;
    rsp_ready = 1'b1;
    build_tables();

    // Pin the model on known values.
    chk("pin_sbox_53", 32'(sbox_t[8'h53]), 32'h000000ed);
    chk("pin_isbox_63", 32'(isbox_t[8'h63]), 32'h00000000);
    chk("pin_mixcol", model_col(1'b0, 1'b1, 32'h455313db, 32'h0), 32'hbca14d8e);

    repeat (2) @(posedge g_clk);
    #2 g_resetn = 1'b1;
    repeat (2) @(posedge g_clk);

    run_req("t1_enc_sbox_zero", 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h63636363);
    run_req("t2_enc_sbox_53", 1'b0, 1'b0, 32'h00000053, 32'hffffffff, 32'h9c9c9c12);
    run_req("t3_enc_mix", 1'b0, 1'b1, 32'h455313db, 32'h00000000, 32'hbca14d8e);
    run_req("t3_dec_mix", 1'b1, 1'b1, 32'hbca14d8e, 32'h00000000, 32'h455313db);
    run_req("t4_dec_sbox", 1'b1, 1'b0, 32'h63636363, 32'h00000000, 32'h00000000);
    run_req("t3b_enc_mix_key", 1'b0, 1'b1, 32'h455313db, 32'h11111111, 32'hadb05c9f);

    // Back-pressure: response held 10 cycles, second request waits.
    @(posedge g_clk); #1;
    base      = n_acc;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_dec   = 1'b0;
    req_mix   = 1'b0;
    req_rs1   = 32'h00000053;
    req_rs2   = 32'hffffffff;
    wait_acc(base);
    req_dec   = 1'b1;
    req_mix   = 1'b1;
    req_rs1   = 32'hbca14d8e;
    req_rs2   = 32'h00000000;
    repeat (14) @(posedge g_clk);
    #1;
    base      = n_done;
    rsp_ready = 1'b1;
    wait_done(base);
    chk("t5_first_rsp", last_rsp, 32'h9c9c9c12);
    base = n_acc;
    wait_acc(base);
    req_valid = 1'b0;
    base      = n_done;
    wait_done(base);
    chk("t5_second_rsp", last_rsp, 32'h455313db);

    // Reset in the second BUSY cycle.
    @(posedge g_clk); #1;
    base      = n_acc;
    req_valid = 1'b1;
    req_dec   = 1'b0;
    req_mix   = 1'b1;
    req_rs1   = 32'h455313db;
    req_rs2   = 32'h0;
    wait_acc(base);
    req_valid = 1'b0;
    base      = n_done;
    @(posedge g_clk);
    #2 g_resetn = 1'b0;
    #6 g_resetn = 1'b1;
    repeat (10) @(posedge g_clk);
    chk("t6_no_rsp_after_reset", 32'(n_done - base), 32'd0);
    run_req("t6_after_reset", 1'b1, 1'b0, 32'h63636363, 32'h01020304, 32'h01020304);

    repeat (3) @(posedge g_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
